// File: rtl/period_meter_pkg.sv
// Shared types and constants for the SIN period meter.
// FSM encoding and default counter width live here.
package period_meter_pkg;

  localparam int WIDTH_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    MEAS = 2'b10
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input.
// A third flop provides rising-edge detect.
module sync_edge (
  input  logic CIN,
  input  logic RSTN,
  input  logic D,
  output logic EDGE
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge CIN or negedge RSTN) begin
    if (!RSTN) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= D;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign EDGE = r_s2 & ~r_s3;

endmodule

// File: rtl/period_meter.sv
// Measures the SIN period in CIN cycles between rising edges.
// Saturating counter, sticky overflow, one-cycle VALID strobe.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CIN,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             SIN,
  output logic [WIDTH-1:0] PERIOD,
  output logic             VALID,
  output logic             OVF,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       r_rst;
  logic             w_rst_n;
  logic             w_edge;
  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_ovf;
  logic             r_busy;

  // Assert asynchronously, release on CIN.
  always_ff @(posedge CIN or negedge RSTN) begin
    if (!RSTN) begin
      r_rst <= 2'b00;
    end else begin
      r_rst <= {r_rst[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst[1];

  sync_edge u_sync (
    .CIN  (CIN),
    .RSTN (w_rst_n),
    .D    (SIN),
    .EDGE (w_edge)
  );

  always_ff @(posedge CIN or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!EN) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state <= ARM;
            r_busy  <= 1'b1;
          end
          ARM: begin
            if (w_edge) begin
              r_cnt   <= CNT_ONE;
              r_state <= MEAS;
            end
          end
          MEAS: begin
            if (w_edge) begin
              r_period <= r_cnt;
              r_valid  <= 1'b1;
              r_ovf    <= 1'b0;
              r_cnt    <= CNT_ONE;
            end else if (r_cnt == CNT_MAX) begin
              // Saturated: drop this period and rearm.
              r_ovf   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ARM;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign PERIOD = r_period;
  assign VALID  = r_valid;
  assign OVF    = r_ovf;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter (WIDTH=8).
// Generator pushes expected periods; monitor checks VALIDs.
module tb_period_meter;

  localparam int W    = 8;
  localparam int MAXC = 255;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         sin   = 1'b0;
  logic [W-1:0] period;
  logic         valid;
  logic         ovf;
  logic         busy;

  period_meter #(.WIDTH(W)) dut (
    .CIN    (clk),
    .RSTN   (rst_n),
    .EN     (en),
    .SIN    (sin),
    .PERIOD (period),
    .VALID  (valid),
    .OVF    (ovf),
    .BUSY   (busy)
  );

  always #50 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int exp_q[$];
  int e_val;
  int cyc       = 0;
  int last_rise = 0;
  bit started   = 1'b0;
  bit rnd_mode  = 1'b0;
  int rnd_n     = 0;
  int rnd_sum   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Monitor: every VALID must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (rnd_mode) begin
        checks++;
        rnd_n++;
        rnd_sum += int'(period);
        if (period < 8'd99 || period > 8'd101) begin
          failures++;
          $display("FAIL rnd_period: got %0d expected 99..101",
                   period);
        end
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got period %0d expected none",
                 period);
      end else begin
        e_val = exp_q.pop_front();
        chk("period", int'(period), e_val);
        chk("ovf_on_valid", int'(ovf), 0);
      end
    end
  end

  // Called at a negedge: raise SIN and predict the resulting VALID.
  task automatic rise();
    int gap;
    gap = cyc - last_rise;
    sin = 1'b1;
    if (en && started && gap <= MAXC) exp_q.push_back(gap);
    started   = en;
    last_rise = cyc;
  endtask

  task automatic gen(int p);
    rise();
    repeat (p / 2) @(negedge clk);
    sin = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    chk("busy_first_edge", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("busy_armed", int'(busy), 1);

    // Divide-by-2, then 10 switching to 7.
    repeat (8) gen(2);
    repeat (5) gen(10);
    repeat (5) gen(7);

    // EN drops 3 cycles before the next edge.
    repeat (3) gen(10);
    rise();
    repeat (5) @(negedge clk);
    sin = 1'b0;
    repeat (2) @(negedge clk);
    en      = 1'b0;
    started = 1'b0;
    @(negedge clk);
    chk("busy_en_off", int'(busy), 0);
    repeat (2) @(negedge clk);
    rise();
    repeat (5) @(negedge clk);
    sin = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    repeat (3) gen(10);

    // Overflow: SIN static after one edge.
    rise();
    repeat (5) @(negedge clk);
    sin = 1'b0;
    repeat (195) @(negedge clk);
    chk("ovf_early", int'(ovf), 0);
    repeat (100) @(negedge clk);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_busy", int'(busy), 1);
    chk("ovf_period_held", int'(period), 10);
    repeat (3) gen(10);
    chk("ovf_cleared", int'(ovf), 0);

    // Largest period that fits the counter.
    gen(255);
    gen(255);
    gen(10);

    // Asynchronous reset mid-measurement.
    repeat (2) gen(10);
    repeat (4) @(negedge clk);
    #13 rst_n = 1'b0;
    #1;
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_busy", int'(busy), 0);
    started = 1'b0;
    repeat (3) @(negedge clk);
    #17 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    repeat (4) gen(10);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    // Random phase, period 100.
    en      = 1'b0;
    started = 1'b0;
    repeat (5) @(negedge clk);
    rnd_mode = 1'b1;
    en       = 1'b1;
    repeat (5) @(negedge clk);
    #($urandom_range(1, 49));
    for (int i = 0; i < 20; i++) begin
      sin = 1'b1;
      #5000;
      sin = 1'b0;
      #5000;
    end
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rnd_mode = 1'b0;
    chk("rnd_count", rnd_n, 19);
    checks++;
    if (rnd_sum < 1899 || rnd_sum > 1901) begin
      failures++;
      $display("FAIL rnd_avg: got sum %0d expected 1900+-1",
               rnd_sum);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
